// File: rtl/pwm_multi_if.sv
// rtl/pwm_multi_if.sv - register bus between a host and pwm_multi
interface pwm_multi_if;
    logic [7:0] address;
    logic [7:0] data_write_in;
    logic       write_en;
    logic [7:0] data_read_out;

    modport master (
        output address,
        output data_write_in,
        output write_en,
        input  data_read_out
    );

    modport slave (
        input  address,
        input  data_write_in,
        input  write_en,
        output data_read_out
    );
endinterface

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared prescaler, edge/center modes, shadowed duty
module pwm_multi #(
    parameter int         N_CH      = 4,
    parameter int         WIDTH     = 8,
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic            clock_in,
    input  logic            reset,
    input  logic            ena,
    pwm_multi_if.slave      bus,
    output logic [N_CH-1:0] pwm_out,
    output logic            period_sync
);
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [2:0]       ctrl;
    logic [7:0]       prescale;
    logic [7:0]       presc;
    logic [WIDTH-1:0] duty_sh  [N_CH];
    logic [WIDTH-1:0] duty_act [N_CH];
    logic [WIDTH-1:0] cnt, cnt_next;
    dir_t             dir, dir_next;

    logic [7:0] offs;
    logic       wr_ctrl, wr_presc;
    logic       run, tick, period_start, mode_restart;

    assign offs     = bus.address - BASE_ADDR;
    assign wr_ctrl  = bus.write_en && (offs == 8'd0);
    assign wr_presc = bus.write_en && (offs == 8'(N_CH + 1));

    assign run          = ena & ctrl[0];
    assign tick         = run && (presc == prescale);
    assign period_start = tick && (cnt == '0);
    assign period_sync  = period_start;
    // Only a change of MODE while running restarts the period.
    assign mode_restart = run && wr_ctrl && (bus.data_write_in[1] != ctrl[1]);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_next;
            dir <= dir_next;
        end
    end

    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        if (!run || mode_restart) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (tick) begin
            if (!ctrl[1]) begin
                cnt_next = cnt + ONE;
                dir_next = DIR_UP;
            end else if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    cnt_next = MAX - ONE;
                    dir_next = DIR_DOWN;
                end else begin
                    cnt_next = cnt + ONE;
                end
            end else begin
                cnt_next = cnt - ONE;
                if (cnt == ONE) dir_next = DIR_UP;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= '0;
            presc    <= '0;
            pwm_out  <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                duty_sh[ch]  <= '0;
                duty_act[ch] <= '0;
            end
        end else begin
            if (wr_ctrl)  ctrl     <= bus.data_write_in[2:0];
            if (wr_presc) prescale <= bus.data_write_in;

            // A prescaler already past a newly lowered limit falls back to 0.
            if (!run)                  presc <= '0;
            else if (presc >= prescale) presc <= '0;
            else                       presc <= presc + 8'd1;

            for (int ch = 0; ch < N_CH; ch++) begin
                if (bus.write_en && (offs == 8'(ch + 1)))
                    duty_sh[ch] <= bus.data_write_in[WIDTH-1:0];
                // Non-blocking read of duty_sh keeps a same-cycle write out of this load.
                if (period_start || mode_restart)
                    duty_act[ch] <= duty_sh[ch];
                pwm_out[ch] <= run ? ((cnt < duty_act[ch]) ^ ctrl[2]) : ctrl[2];
            end
        end
    end

    always_comb begin
        bus.data_read_out = 8'h00;
        if (offs == 8'd0) begin
            bus.data_read_out = {5'b0, ctrl};
        end else if (offs == 8'(N_CH + 1)) begin
            bus.data_read_out = prescale;
        end else begin
            for (int ch = 0; ch < N_CH; ch++)
                if (offs == 8'(ch + 1)) bus.data_read_out = 8'(duty_sh[ch]);
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi
module tb_pwm_multi;
    logic       clock_in;
    logic       reset;
    logic       ena;
    logic [3:0] pwm_out;
    logic       period_sync;

    pwm_multi_if bus ();

    pwm_multi #(.N_CH(4), .WIDTH(8), .BASE_ADDR(8'h10)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .ena         (ena),
        .bus         (bus.slave),
        .pwm_out     (pwm_out),
        .period_sync (period_sync)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: period position as a phase index k within a period of 256 (edge) or 510 (center) ticks.
    logic [2:0] m_ctrl = '0;
    logic [7:0] m_sh  [4] = '{default: '0};
    logic [7:0] m_act [4] = '{default: '0};
    logic [7:0] m_pre = '0;
    int         m_p   = 0;
    int         m_k   = 0;
    logic [3:0] m_pwm = '0;
    logic       mr, mt, mrestart;
    int         mc;

    function automatic int plen(logic center);
        return center ? 510 : 256;
    endfunction

    function automatic int pos(logic center, int k);
        if (!center) return k;
        return (k <= 255) ? k : 510 - k;
    endfunction

    function automatic logic [7:0] exp_rd(logic [7:0] a);
        if (a == 8'h10) return {5'b0, m_ctrl};
        if (a >= 8'h11 && a <= 8'h14) return m_sh[a - 8'h11];
        if (a == 8'h15) return m_pre;
        return 8'h00;
    endfunction

    always @(posedge clock_in) begin
        if (reset) begin
            m_ctrl = '0; m_pre = '0; m_p = 0; m_k = 0; m_pwm = '0;
            for (int c = 0; c < 4; c++) begin m_sh[c] = '0; m_act[c] = '0; end
        end else begin
            mr = ena && m_ctrl[0];
            mc = pos(m_ctrl[1], m_k);
            mt = mr && (m_p == int'(m_pre));
            mrestart = mr && bus.write_en && bus.address == 8'h10
                       && (bus.data_write_in[1] != m_ctrl[1]);
            for (int c = 0; c < 4; c++)
                m_pwm[c] = mr ? ((mc < int'(m_act[c])) ^ m_ctrl[2]) : m_ctrl[2];
            if ((mt && mc == 0) || mrestart)
                for (int c = 0; c < 4; c++) m_act[c] = m_sh[c];
            if (!mr) begin
                m_p = 0; m_k = 0;
            end else begin
                m_p = (m_p >= int'(m_pre)) ? 0 : m_p + 1;
                if (mrestart) m_k = 0;
                else if (mt) m_k = (m_k + 1) % plen(m_ctrl[1]);
            end
            if (bus.write_en) begin
                if (bus.address == 8'h10) m_ctrl = bus.data_write_in[2:0];
                if (bus.address >= 8'h11 && bus.address <= 8'h14)
                    m_sh[bus.address - 8'h11] = bus.data_write_in;
                if (bus.address == 8'h15) m_pre = bus.data_write_in;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_cyc();
        logic es;
        @(posedge clock_in);
        #2;
        es = ena && m_ctrl[0] && (m_p == int'(m_pre)) && (pos(m_ctrl[1], m_k) == 0);
        chk("model_pwm",  32'(pwm_out), 32'(m_pwm));
        chk("model_sync", 32'(period_sync), 32'(es));
        chk("model_rd",   32'(bus.data_read_out), 32'(exp_rd(bus.address)));
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        bus.address = a; bus.data_write_in = d; bus.write_en = 1'b1;
        tick_cyc();
        bus.write_en = 1'b0;
    endtask

    task automatic wait_sync();
        int n = 0;
        do begin tick_cyc(); n++; end while (period_sync !== 1'b1 && n < 2100);
        chk("sync_seen", 32'(period_sync), 32'd1);
    endtask

    int hi [4];
    int syncs;

    task automatic clr_meas();
        for (int c = 0; c < 4; c++) hi[c] = 0;
        syncs = 0;
    endtask

    task automatic measure(int n);
        for (int i = 0; i < n; i++) begin
            tick_cyc();
            bus.write_en = 1'b0;
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
            syncs += int'(period_sync);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [12];

    initial begin
        vecs[0]  = '{8'h10, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{8'h11, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{8'h12, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{8'h13, 8'h00, 1'b0, 8'h00};
        vecs[4]  = '{8'h14, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{8'h15, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{8'h10, 8'hFF, 1'b1, 8'h07};
        vecs[7]  = '{8'h12, 8'hAB, 1'b1, 8'hAB};
        vecs[8]  = '{8'h15, 8'h5A, 1'b1, 8'h5A};
        vecs[9]  = '{8'h16, 8'h77, 1'b1, 8'h00};
        vecs[10] = '{8'h0F, 8'h33, 1'b1, 8'h00};
        vecs[11] = '{8'h14, 8'h3C, 1'b1, 8'h3C};

        reset = 1'b1; ena = 1'b0;
        bus.address = 8'h00; bus.data_write_in = 8'h00; bus.write_en = 1'b0;
        tick_cyc(); tick_cyc();
        reset = 1'b0;
        chk("reset_pwm", 32'(pwm_out), 32'h0);
        chk("reset_sync", 32'(period_sync), 32'h0);

        foreach (vecs[i]) begin
            bus.address = vecs[i].addr; bus.data_write_in = vecs[i].wdata;
            bus.write_en = vecs[i].we;
            tick_cyc();
            bus.write_en = 1'b0;
            #1 chk($sformatf("vec%0d_rd", i), 32'(bus.data_read_out), 32'(vecs[i].exp));
        end

        // Edge mode, duty 64/256
        reset = 1'b1; tick_cyc(); reset = 1'b0;
        wr(8'h11, 8'h40); wr(8'h10, 8'h01); ena = 1'b1;
        wait_sync(); wait_sync();
        clr_meas(); measure(256);
        chk("edge_hi64", 32'(hi[0]), 32'd64);
        chk("edge_sync", 32'(syncs), 32'd1);
        chk("edge_sync_end", 32'(period_sync), 32'd1);

        // Inverted: duty 0 constant high, duty MAX one cycle high
        wr(8'h12, 8'h00); wr(8'h13, 8'hFF); wr(8'h10, 8'h05);
        wait_sync(); wait_sync();
        clr_meas(); measure(256);
        chk("inv_d0", 32'(hi[1]), 32'd256);
        chk("inv_dmax", 32'(hi[2]), 32'd1);
        chk("inv_d40", 32'(hi[0]), 32'd192);

        // Shadowed duty updates
        wr(8'h10, 8'h01);
        wait_sync(); wait_sync();
        clr_meas(); measure(32);
        bus.address = 8'h11; bus.data_write_in = 8'hC0; bus.write_en = 1'b1;
        measure(224);
        chk("shadow_cur", 32'(hi[0]), 32'd64);
        chk("shadow_at_sync", 32'(period_sync), 32'd1);
        clr_meas(); measure(256);
        chk("shadow_next", 32'(hi[0]), 32'd192);
        bus.address = 8'h11; bus.data_write_in = 8'h80; bus.write_en = 1'b1;
        clr_meas(); measure(256);
        chk("sync_wr_old", 32'(hi[0]), 32'd192);
        clr_meas(); measure(256);
        chk("sync_wr_new", 32'(hi[0]), 32'd128);

        // Center mode with prescale 1
        reset = 1'b1; tick_cyc(); reset = 1'b0;
        wr(8'h15, 8'h01); wr(8'h14, 8'h80); wr(8'h10, 8'h03);
        wait_sync(); wait_sync();
        chk("center_at_sync", 32'(pwm_out[3]), 32'd1);
        clr_meas(); measure(510);
        chk("center_mid_low", 32'(pwm_out[3]), 32'd0);
        measure(510);
        chk("center_hi", 32'(hi[3]), 32'd510);
        chk("center_sync", 32'(syncs), 32'd1);
        chk("center_end_sync", 32'(period_sync), 32'd1);

        // Reset mid-period overriding a write
        repeat (37) tick_cyc();
        reset = 1'b1; bus.address = 8'h10; bus.data_write_in = 8'h07; bus.write_en = 1'b1;
        tick_cyc();
        reset = 1'b0; bus.write_en = 1'b0;
        chk("midrst_pwm", 32'(pwm_out), 32'h0);
        chk("midrst_sync", 32'(period_sync), 32'h0);
        for (int a = 8'h10; a <= 8'h15; a++) begin
            bus.address = 8'(a);
            #1 chk($sformatf("midrst_rd%0h", a), 32'(bus.data_read_out), 32'h0);
        end

        // Drop and re-raise ena
        wr(8'h11, 8'h40); wr(8'h10, 8'h05);
        repeat (100) tick_cyc();
        ena = 1'b0;
        tick_cyc();
        chk("ena_off_pwm", 32'(pwm_out), 32'hF);
        chk("ena_off_sync", 32'(period_sync), 32'h0);
        repeat (5) tick_cyc();
        ena = 1'b1;
        #1 chk("ena_rise_sync", 32'(period_sync), 32'd1);
        tick_cyc();

        // Random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 63) == 0) ena = ~ena;
            bus.address = 8'(8'h0F + $urandom_range(0, 7));
            bus.data_write_in = (bus.address == 8'h15) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            bus.write_en = ($urandom_range(0, 15) == 0);
            tick_cyc();
        end
        reset = 1'b0; bus.write_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of PWM channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, counter/duty resolution in bits (2..8).
REQ-003 SHALL have parameter BASE_ADDR, default 8'h10, first register-bank address.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clock_in  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ena  input  1  block enable, ANDed with CTRL.EN.
REQ-007 address  input  8  register-bank address.
REQ-008 data_write_in  input  8  register write data.
REQ-009 write_en  input  1  one-cycle write strobe.
REQ-010 data_read_out  output  8  register read data.
REQ-011 pwm_out  output  N_CH  PWM outputs, bit ch = channel ch.
REQ-012 period_sync  output  1  one-cycle pulse at each period start.

Function
REQ-013 SHALL map registers: BASE_ADDR+0 CTRL (bit0 EN, bit1 MODE 0=edge/1=center, bit2 INV); BASE_ADDR+1+ch DUTY[ch], low WIDTH bits; BASE_ADDR+1+N_CH PRESCALE (8 bits).
REQ-014 Register write SHALL occur on the clock edge where write_en=1 and address matches. Writes to unmapped addresses SHALL be ignored. DUTY bits above WIDTH SHALL be dropped.
REQ-015 data_read_out SHALL be combinational from address: CTRL in bits[2:0], the DUTY shadow zero-extended, or PRESCALE. Unmapped addresses SHALL read 8'h00.
REQ-016 run = ena & CTRL.EN. When run=0, the prescaler and counter SHALL be held at 0, the direction SHALL be up, and pwm_out SHALL be registered to {N_CH{CTRL.INV}}.
REQ-017 The prescaler SHALL count 0..PRESCALE. tick=1 when prescaler==PRESCALE, and the prescaler then wraps to 0. PRESCALE=0 gives a tick every cycle.
REQ-018 Edge mode: on tick, cnt SHALL increment 0..MAX (MAX=2^WIDTH-1) and wrap to 0. Period = 2^WIDTH ticks.
REQ-019 Center mode: on tick, cnt SHALL count up 0..MAX, then down MAX-1..1, then return to 0. Period = 2*MAX ticks.
REQ-020 Period start SHALL be defined as cnt==0 on a tick, including the first tick after run rises. At period start, all DUTY shadows SHALL copy into the active duty registers and period_sync SHALL pulse for that one cycle.
REQ-021 A DUTY write in the same cycle as a period-start load SHALL NOT affect that load. The active register takes the pre-write shadow value, and the new value applies from the following period.
REQ-022 pwm_out[ch] SHALL be registered, 1 cycle after the compare, as (cnt < duty_act[ch]) XOR CTRL.INV.
REQ-023 DUTY=0 SHALL give a constant inactive level. DUTY=MAX in edge mode SHALL give inactive for exactly 1 tick per period.
REQ-024 A write to CTRL.MODE while run=1 SHALL restart cnt at 0 with direction up on the next cycle, and SHALL reload the active duty registers.
REQ-025 A PRESCALE write SHALL take effect immediately. If the prescaler is currently above the new value, it SHALL wrap to 0 on the next cycle.

Reset
REQ-026 On reset=1 at a clock edge, SHALL clear: CTRL, all DUTY shadow and active registers, PRESCALE, prescaler, cnt and direction (up). Outputs SHALL be pwm_out=0 and period_sync=0.
REQ-027 Reset SHALL override simultaneous write_en. Reset mid-period SHALL abort the period with no period_sync.

Verification (N_CH=4, WIDTH=8, BASE_ADDR=8'h10)
REQ-028 Reset, then read 0x10..0x15 -> all 8'h00; pwm_out=4'b0000; period_sync=0.
REQ-029 PRESCALE=0, DUTY0=0x40, CTRL=0x01, ena=1 -> pwm_out[0] high 64 of every 256 cycles; period_sync every 256 cycles.
REQ-030 DUTY1=0x00, DUTY2=0xFF, CTRL=0x05 (inverted) -> pwm_out[1] constant 1; pwm_out[2] high exactly 1 cycle per 256.
REQ-031 Running DUTY0=0x40; write 0xC0 at cnt=0x20 -> the rest of the current period still uses 64; the next period is high 192 cycles. Also write 0x80 exactly in a period_sync cycle -> that period uses the old value.
REQ-032 CTRL=0x03, PRESCALE=1, DUTY3=0x80 -> period 1020 cycles, pwm_out[3] high 510 cycles, centered on cnt=0.
REQ-033 Assert reset mid-period, and separately drop ena mid-period -> reset gives pwm_out=0 and registers cleared; ena=0 gives pwm_out={4{INV}}; ena re-rise gives period_sync on the first tick.
